// File: rtl/vote_pkg.sv
// Shared types and constants for the 5-voter session controller and its popcount helper.
package vote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPEN,
        ST_TALLY,
        ST_RESULT
    } vote_state_t;

    localparam int unsigned N_VOTERS      = 5;
    localparam int unsigned MAJ_THRESHOLD = 3;
    localparam int unsigned COUNT_W       = 3;

endpackage

// File: rtl/vote_popcount5.sv
// Combinational 5-bit popcount with a majority (>= MAJ_THRESHOLD) flag.
module vote_popcount5
    import vote_pkg::*;
(
    input  logic [N_VOTERS-1:0] bits,
    output logic [COUNT_W-1:0]  count,
    output logic                majority
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < N_VOTERS; i++) begin
            count = count + COUNT_W'(bits[i]);
        end
        majority = (count >= COUNT_W'(MAJ_THRESHOLD));
    end

endmodule

// File: rtl/vote_session_ctrl.sv
// Timed voting-window controller: captures one ballot per voter, tallies, holds the decision.
// Optional macro VOTE_SYNC_EN adds 2-flop synchronizers on vote_yes, vote_no, start and abort.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned CNT_W         = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [N_VOTERS-1:0] vote_yes,
    input  logic [N_VOTERS-1:0] vote_no,
    output logic                busy,
    output logic [N_VOTERS-1:0] voted_mask,
    output logic                result_valid,
    output logic                pass,
    output logic [COUNT_W-1:0]  yes_count,
    output logic                timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);

    logic [N_VOTERS-1:0] yes_in, no_in;
    logic                start_in, abort_in;

`ifdef VOTE_SYNC_EN
    logic [N_VOTERS-1:0] yes_s1_q, yes_s2_q, no_s1_q, no_s2_q;
    logic                start_s1_q, start_s2_q, abort_s1_q, abort_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yes_s1_q   <= '0;
            yes_s2_q   <= '0;
            no_s1_q    <= '0;
            no_s2_q    <= '0;
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            abort_s1_q <= 1'b0;
            abort_s2_q <= 1'b0;
        end else begin
            yes_s1_q   <= vote_yes;
            yes_s2_q   <= yes_s1_q;
            no_s1_q    <= vote_no;
            no_s2_q    <= no_s1_q;
            start_s1_q <= start;
            start_s2_q <= start_s1_q;
            abort_s1_q <= abort;
            abort_s2_q <= abort_s1_q;
        end
    end

    always_comb begin
        yes_in   = yes_s2_q;
        no_in    = no_s2_q;
        start_in = start_s2_q;
        abort_in = abort_s2_q;
    end
`else
    always_comb begin
        yes_in   = vote_yes;
        no_in    = vote_no;
        start_in = start;
        abort_in = abort;
    end
`endif

    vote_state_t         state_q, state_d;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic [N_VOTERS-1:0] ballot_q, ballot_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pass_q, pass_d;
    logic [COUNT_W-1:0]  yes_count_q, yes_count_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic                result_valid_q, result_valid_d;

    logic [N_VOTERS-1:0] capture, mask_next;
    logic [COUNT_W-1:0]  tally_count;
    logic                tally_pass;
    logic                clear_session;

    vote_popcount5 u_popcount (
        .bits     (ballot_q),
        .count    (tally_count),
        .majority (tally_pass)
    );

    always_comb begin
        state_d       = state_q;
        voted_d       = voted_q;
        ballot_d      = ballot_q;
        cnt_d         = cnt_q;
        pass_d        = pass_q;
        yes_count_d   = yes_count_q;
        timeout_d     = timeout_q;
        clear_session = 1'b0;

        // Only unlocked voters with exactly one button pressed capture.
        capture   = ~voted_q & (yes_in ^ no_in);
        mask_next = voted_q | capture;

        unique case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d       = ST_OPEN;
                    clear_session = 1'b1;
                end
            end
            ST_OPEN: begin
                if (abort_in) begin
                    state_d       = ST_IDLE;
                    clear_session = 1'b1;
                end else begin
                    voted_d  = mask_next;
                    ballot_d = ballot_q | (capture & yes_in);
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (&mask_next) begin
                        state_d   = ST_TALLY;
                        timeout_d = 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = ST_TALLY;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_TALLY: begin
                yes_count_d = tally_count;
                pass_d      = tally_pass;
                state_d     = ST_RESULT;
            end
            ST_RESULT: begin
                if (abort_in) begin
                    state_d       = ST_IDLE;
                    clear_session = 1'b1;
                end else if (start_in) begin
                    state_d       = ST_OPEN;
                    clear_session = 1'b1;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                clear_session = 1'b1;
            end
        endcase

        if (clear_session) begin
            voted_d     = '0;
            ballot_d    = '0;
            cnt_d       = '0;
            pass_d      = 1'b0;
            yes_count_d = '0;
            timeout_d   = 1'b0;
        end

        busy_d         = (state_d == ST_OPEN) || (state_d == ST_TALLY);
        result_valid_d = (state_d == ST_RESULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            voted_q        <= '0;
            ballot_q       <= '0;
            cnt_q          <= '0;
            pass_q         <= 1'b0;
            yes_count_q    <= '0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            voted_q        <= voted_d;
            ballot_q       <= ballot_d;
            cnt_q          <= cnt_d;
            pass_q         <= pass_d;
            yes_count_q    <= yes_count_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    always_comb begin
        busy         = busy_q;
        voted_mask   = voted_q;
        result_valid = result_valid_q;
        pass         = pass_q;
        yes_count    = yes_count_q;
        timeout      = timeout_q;
    end

endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
- Sequential front end for the 5-voter majority logic.
- Opens a timed voting window and captures exactly one yes/no ballot per voter from push-button inputs.
- Closes on all-voted or timeout, tallies the ballots, and holds a registered pass/fail decision for display.
- Sits between the voter button panel and the result LEDs/display driver.

Parameters:
- WINDOW_CYCLES, 1000, length of the voting window in clk cycles (>=2).
- CNT_W, 10, width of the window counter; must satisfy 2**CNT_W >= WINDOW_CYCLES.

Ports:
- clk  input  1  system clock; the block uses one clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; opens a new session from IDLE or RESULT.
- abort  input  1  level; cancels an open session.
- vote_yes  input  5  bit i high = voter i presses yes.
- vote_no  input  5  bit i high = voter i presses no.
- busy  output  1  high while in OPEN or TALLY.
- voted_mask  output  5  bit i set once voter i has cast a ballot.
- result_valid  output  1  high in RESULT.
- pass  output  1  registered majority decision (yes_count >= 3).
- yes_count  output  3  number of yes ballots, 0..5.
- timeout  output  1  high in RESULT when the session closed by timeout.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; all outputs 0; ballot registers and counter cleared.
- States: IDLE, OPEN, TALLY, RESULT.
- IDLE:
  - start -> OPEN.
  - Entering OPEN clears ballots, voted_mask, counter, pass, yes_count and timeout.
- OPEN, per voter i:
  - A ballot is captured in the first cycle in which exactly one of vote_yes[i] or vote_no[i] is high.
  - Capture sets voted_mask[i] and stores yes=1 or no=0.
  - Once captured, the ballot is locked; later presses are ignored.
  - Both inputs high in the same cycle: no capture that cycle.
- OPEN, window counter:
  - Increments every cycle in OPEN.
- OPEN, transitions (priority high to low):
  - abort -> IDLE; ballots discarded; no result.
  - voted_mask becomes 11111 (including a capture in this cycle) -> TALLY; timeout=0.
  - counter == WINDOW_CYCLES-1 -> TALLY; timeout=1.
  - A vote captured on the timeout cycle still counts.
  - Voters who have not voted count as no.
- start while in OPEN or TALLY: ignored.
- TALLY (exactly 1 cycle):
  - yes_count = popcount of the yes ballots.
  - pass = (yes_count >= 3).
  - Both registered; next state RESULT.
- RESULT:
  - result_valid=1; pass, yes_count, timeout and voted_mask are held stable.
  - start -> OPEN (new session; outputs cleared on entry).
  - abort in RESULT -> IDLE; all outputs cleared.
- Latency:
  - Last ballot captured at edge N -> state TALLY after edge N.
  - result_valid = 1 after edge N+1.
- Width: yes_count is 3 bits; the counter saturates logic by leaving OPEN, so it never wraps.
- Reset asserted mid-session: immediate return to IDLE; all outputs 0.

Optional Feature:
- Macro VOTE_SYNC_EN.
- When defined:
  - vote_yes, vote_no, start and abort each pass through a 2-flop synchronizer before use.
  - Adds 2 cycles of input-to-capture latency.
  - Synchronizer flops reset to 0.
- When undefined:
  - Inputs are used directly; they are assumed synchronous to clk.
  - Capture happens at the first clk edge with the input high.

Decomposition:
- Shared package vote_pkg:
  - State encoding typedef (IDLE, OPEN, TALLY, RESULT).
  - N_VOTERS=5.
  - MAJ_THRESHOLD=3.
  - Count width constant (3).
- Sub-module vote_popcount5: combinational 5-bit popcount plus a >=MAJ_THRESHOLD compare.
  - Instantiated in the TALLY path.
  - Reusable by the existing gate-level voter as a cross-check.

Test Plan:
- Reset then start; voters 0,1,2 yes and 3,4 no on separate cycles -> all-voted close; yes_count=3, pass=1, timeout=0, voted_mask=11111, result_valid 2 cycles after last vote.
- Start; voter 0 yes, voter 1 yes, others silent; WINDOW_CYCLES=16 -> after 16 OPEN cycles timeout=1, yes_count=2, pass=0, voted_mask=00011.
- Voter 2 presses yes then no, and voter 3 presses both simultaneously for 1 cycle then no -> voter 2 counted yes; voter 3 counted no only from the second press.
- Abort mid-OPEN after 3 yes votes -> IDLE, busy=0, result_valid=0, all outputs 0; a following start and 5 no votes -> pass=0, yes_count=0.
- From RESULT (pass=1), pulse start -> outputs cleared next cycle, busy=1; rst_n low mid-session -> asynchronous clear of all outputs without a clock edge.
- With VOTE_SYNC_EN defined: a vote pulse of 1 cycle held through the synchronizers -> voted_mask bit sets 2 cycles later than in the undefined build.
